// File: rtl/wm_reshape_pack_pkg.sv
// Shared definitions for the weight-matrix repacker.
//  - one-hot FSM state encodings
//  - default narrow-read byte increment and default source/destination bases
package wm_reshape_pack_pkg;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_PREP  = 5'b00010,
    ST_RUN   = 5'b00100,
    ST_DRAIN = 5'b01000,
    ST_DONE  = 5'b10000
  } wm_state_t;

  localparam int          DEF_SRC_INCR = 4;
  localparam logic [31:0] DEF_SRC_BASE = 32'h0000_0000;
  localparam logic [15:0] DEF_DST_BASE = 16'h0000;

endpackage

// File: rtl/wm_reshape_pack_if.sv
// Memory-side bus bundle of the repacker.
//  master (repacker): src_en/src_addr out, src_rddata in; dst_we/dst_addr/dst_wrdata out
//  slave  (memories): the mirror image
interface wm_reshape_pack_if #(
  parameter int DW     = 32,
  parameter int LANES  = 4,
  parameter int SRC_AW = 32,
  parameter int DST_AW = 16
);

  logic                  src_en;
  logic [SRC_AW-1:0]     src_addr;
  logic [DW-1:0]         src_rddata;
  logic                  dst_we;
  logic [DST_AW-1:0]     dst_addr;
  logic [DW*LANES-1:0]   dst_wrdata;

  modport master (
    output src_en, src_addr,
    input  src_rddata,
    output dst_we, dst_addr, dst_wrdata
  );

  modport slave (
    input  src_en, src_addr,
    output src_rddata,
    input  dst_we, dst_addr, dst_wrdata
  );

endinterface

// File: rtl/wm_reshape_pack_packer.sv
// wm_lane_packer: gathers narrow words into one wide entry.
//  clk, rst_n     clock, async active-low reset
//  valid          data word present this cycle
//  lane           target lane of the word
//  last           word is the last column of its row (closes the entry early)
//  data           narrow word
//  entry_valid    registered: a completed entry is presented this cycle
//  entry_data     registered completed entry; lane 0 in the low bits
module wm_lane_packer #(
  parameter int DW    = 32,
  parameter int LANES = 4,
  parameter int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid,
  input  logic [LW-1:0]       lane,
  input  logic                last,
  input  logic [DW-1:0]       data,
  output logic                entry_valid,
  output logic [DW*LANES-1:0] entry_data
);

  logic [DW*LANES-1:0] acc_reg;
  logic [DW*LANES-1:0] acc_next;
  logic                entry_valid_reg;
  logic [DW*LANES-1:0] entry_data_reg;
  logic                complete;

  // A word on lane 0 starts a fresh entry, so every other lane is cleared
  // at the same time; that is what leaves padded lanes at zero.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign acc_next[gi*DW +: DW] =
        !valid               ? acc_reg[gi*DW +: DW] :
        (lane == LW'(gi))    ? data :
        (lane == '0)         ? '0 :
                               acc_reg[gi*DW +: DW];
    end
  endgenerate

  assign complete = valid && ((lane == LW'(LANES-1)) || last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg         <= '0;
      entry_valid_reg <= 1'b0;
      entry_data_reg  <= '0;
    end else begin
      acc_reg         <= acc_next;
      entry_valid_reg <= complete;
      if (complete) entry_data_reg <= acc_next;
    end
  end

  assign entry_valid = entry_valid_reg;
  assign entry_data  = entry_data_reg;

endmodule

// File: rtl/wm_reshape_pack.sv
// wm_reshape_pack: repacks an N x P matrix of narrow words (row-major) into
// wide entries of LANES words, each row padded to ceil(P/LANES) entries.
//  clk, rst_n          clock, async active-low reset
//  start               begin a job (taken in IDLE, or in the DONE cycle)
//  P, N                columns per row, rows
//  src_base, dst_base  narrow byte base, wide entry base
//  busy, done, err     status; done/err are single-cycle pulses
//  mem                 narrow read port and wide write port (master side)
module wm_reshape_pack
  import wm_reshape_pack_pkg::*;
#(
  parameter int DW       = 32,
  parameter int LANES    = 4,
  parameter int SRC_AW   = 32,
  parameter int DST_AW   = 16,
  parameter int SRC_INCR = DEF_SRC_INCR,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  P,
  input  logic [CNT_W-1:0]  N,
  input  logic [SRC_AW-1:0] src_base,
  input  logic [DST_AW-1:0] dst_base,
  output logic              busy,
  output logic              done,
  output logic              err,
  wm_reshape_pack_if.master mem
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  wm_state_t         state_reg;
  logic [CNT_W-1:0]  p_reg, n_reg;
  logic [SRC_AW-1:0] src_base_reg;
  logic [CNT_W-1:0]  col_reg, row_reg;
  logic              src_en_reg;
  logic [SRC_AW-1:0] src_addr_reg;
  logic              busy_reg, done_reg, err_reg;
  logic              tag_valid_reg, tag_last_reg;
  logic [CNT_W-1:0]  tag_col_reg;
  logic [DST_AW-1:0] wr_ptr_reg;

  logic [CNT_W-1:0]  p_last, n_last;
  logic              col_at_end, row_at_end;
  logic [LW-1:0]     tag_lane;
  logic              entry_valid;
  logic [DW*LANES-1:0] entry_data;

  assign p_last     = p_reg - CNT_W'(1);
  assign n_last     = n_reg - CNT_W'(1);
  assign col_at_end = (col_reg == p_last);
  assign row_at_end = (row_reg == n_last);
  assign tag_lane   = LW'(tag_col_reg % CNT_W'(LANES));

  // col/row track the read being presented on the source port this cycle;
  // the tag is that read's bookkeeping, delayed to meet its data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      p_reg         <= '0;
      n_reg         <= '0;
      src_base_reg  <= '0;
      col_reg       <= '0;
      row_reg       <= '0;
      src_en_reg    <= 1'b0;
      src_addr_reg  <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      tag_valid_reg <= 1'b0;
      tag_last_reg  <= 1'b0;
      tag_col_reg   <= '0;
      wr_ptr_reg    <= '0;
    end else begin
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      tag_valid_reg <= 1'b0;
      if (entry_valid) wr_ptr_reg <= wr_ptr_reg + DST_AW'(1);

      unique case (state_reg)
        // DONE behaves like IDLE for start so back-to-back jobs lose no cycle.
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_reg    <= ST_PREP;
            busy_reg     <= 1'b1;
            p_reg        <= P;
            n_reg        <= N;
            src_base_reg <= src_base;
            wr_ptr_reg   <= dst_base;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_PREP: begin
          col_reg <= '0;
          row_reg <= '0;
          if (p_reg == '0 || n_reg == '0) begin
            state_reg <= ST_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            err_reg   <= 1'b1;
          end else begin
            state_reg    <= ST_RUN;
            src_en_reg   <= 1'b1;
            src_addr_reg <= src_base_reg;
          end
        end
        ST_RUN: begin
          tag_valid_reg <= 1'b1;
          tag_col_reg   <= col_reg;
          tag_last_reg  <= col_at_end;
          if (col_at_end && row_at_end) begin
            state_reg  <= ST_DRAIN;
            src_en_reg <= 1'b0;
          end else begin
            src_addr_reg <= src_addr_reg + SRC_AW'(SRC_INCR);
            if (col_at_end) begin
              col_reg <= '0;
              row_reg <= row_reg + CNT_W'(1);
            end else begin
              col_reg <= col_reg + CNT_W'(1);
            end
          end
        end
        // Wait for the last word to reach the packer; its entry is written
        // the following cycle, and done is raised one cycle after that.
        ST_DRAIN: begin
          if (!tag_valid_reg) begin
            state_reg <= ST_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg  <= ST_IDLE;
          busy_reg   <= 1'b0;
          src_en_reg <= 1'b0;
        end
      endcase
    end
  end

  wm_lane_packer #(
    .DW    (DW),
    .LANES (LANES),
    .LW    (LW)
  ) u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid       (tag_valid_reg),
    .lane        (tag_lane),
    .last        (tag_last_reg),
    .data        (mem.src_rddata),
    .entry_valid (entry_valid),
    .entry_data  (entry_data)
  );

  assign busy           = busy_reg;
  assign done           = done_reg;
  assign err            = err_reg;
  assign mem.src_en     = src_en_reg;
  assign mem.src_addr   = src_addr_reg;
  assign mem.dst_we     = entry_valid;
  assign mem.dst_addr   = wr_ptr_reg;
  assign mem.dst_wrdata = entry_data;

endmodule
